// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port RAM arbiter, IDLE/ACCESS/DONE handshake.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_wmask,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_ack,
    input  logic            m1_req,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_wmask,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_ack,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    output logic            mem_rstrb,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_win;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_wmask;
    logic              w_any;
    logic              w_pick;
    logic              w_grant;

    assign w_any   = m0_req | m1_req;
    assign w_grant = (r_state == ST_IDLE) && w_any;

`ifdef MEM_ARBITER_RR_EN
    logic r_last;

    // Reset value 1 makes m0 the first winner on contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_grant)
            r_last <= w_pick;
    end

    assign w_pick = (m0_req && m1_req) ? ~r_last : m1_req;
`else
    assign w_pick = ~m0_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= 4'b0000;
        end else if (w_grant) begin
            r_win   <= w_pick;
            r_addr  <= w_pick ? m1_addr  : m0_addr;
            r_wdata <= w_pick ? m1_wdata : m0_wdata;
            r_wmask <= w_pick ? m1_wmask : m0_wmask;
        end
    end

    // Outputs decode from the state alone, so reset clears every strobe asynchronously.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = 4'b0000;
        mem_rstrb = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (r_state)
            ST_ACCESS: begin
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_wmask = r_wmask;
                mem_rstrb = (r_wmask == 4'b0000);
            end
            ST_DONE: begin
                if (r_win) begin
                    m1_ack   = 1'b1;
                    m1_rdata = (r_wmask == 4'b0000) ? mem_rdata : '0;
                end else begin
                    m0_ack   = 1'b1;
                    m0_rdata = (r_wmask == 4'b0000) ? mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM.
// Expected ack order follows MEM_ARBITER_RR_EN when it is defined for the build.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;

    mem_arbiter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          ack_cnt = 0;
    int          cyc = 0;
    int          ack_cyc[0:63];
    logic [31:0] ram[0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // RAM: read data registered one cycle after the strobe, byte-masked writes.
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4]    = 32'hDEADBEEF;
        ram[8]    = 32'hAAAAAAAA;
        ram[12]   = 32'h3030C0DE;
        ram[16]   = 32'h0BADF00D;
        ram[20]   = 32'h55555555;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (!m0_ack) check("m0_rdata_nonack", m0_rdata, 32'h0);
            if (!m1_ack) check("m1_rdata_nonack", m1_rdata, 32'h0);
            if (m0_ack || m1_ack) begin
                if (m0_ack && m1_ack) check("dual_ack", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_who", {31'h0, m1_ack}, {31'h0, mon_e.who});
                    if (mon_e.chk) check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e.data);
                end
                if (ack_cnt < 64) ack_cyc[ack_cnt] = cyc;
                ack_cnt++;
            end
        end
    end

    task automatic wait_acks(input int target);
        bit done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk);
            if (ack_cnt >= target) done = 1;
        end
        if (!done) check("ack_timeout", ack_cnt, target);
        #1;
    endtask

    int base;

    initial begin
        reset = 1'b1;
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m0_wdata = 0; m0_wmask = 0;
        m1_addr = 0; m1_wdata = 0; m1_wmask = 0;
        repeat (2) @(posedge clk);
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        check("rst_mem_rstrb", {31'h0, mem_rstrb}, 32'h0);
        check("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        m0_req = 0; m1_req = 0;
        @(posedge clk); #1 reset = 1'b0;

        // Single read by m0
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        m0_addr = 32'h10; m0_wmask = 4'b0000; m0_req = 1;
        @(negedge clk);
        check("rd_idle_rstrb", {31'h0, mem_rstrb}, 32'h0);
        @(negedge clk);
        check("rd_access_rstrb", {31'h0, mem_rstrb}, 32'h1);
        check("rd_access_addr", mem_addr, 32'h10);
        check("rd_access_ack", {31'h0, m0_ack}, 32'h0);
        @(negedge clk);
        check("rd_done_rstrb", {31'h0, mem_rstrb}, 32'h0);
        check("rd_done_ack", {31'h0, m0_ack}, 32'h1);
        @(posedge clk); #1 m0_req = 0;

        // Single partial write by m1
        sb.push_back('{1'b1, 1'b0, 32'h0});
        m1_addr = 32'h20; m1_wdata = 32'h12345678; m1_wmask = 4'b0011; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("wr_access_wmask", {28'h0, mem_wmask}, 32'h3);
        check("wr_access_wdata", mem_wdata, 32'h12345678);
        check("wr_access_rstrb", {31'h0, mem_rstrb}, 32'h0);
        @(negedge clk);
        check("wr_done_wmask", {28'h0, mem_wmask}, 32'h0);
        check("wr_done_ack", {31'h0, m1_ack}, 32'h1);
        @(posedge clk); #1 m1_req = 0;
        check("wr_ram", ram[8], 32'hAAAA5678);

        // Contention: both held for four transactions
`ifdef MEM_ARBITER_RR_EN
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b1, 1'b1, 32'h3030C0DE});
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b1, 1'b1, 32'h3030C0DE});
`else
        for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
`endif
        base = ack_cnt;
        m0_addr = 32'h10; m0_wmask = 0;
        m1_addr = 32'h30; m1_wmask = 0;
        m0_req = 1; m1_req = 1;
        wait_acks(base + 4);
        m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);
        check("cont_ack_count", ack_cnt, base + 4);

        // Early drop: request withdrawn during ACCESS still completes once
        sb.push_back('{1'b0, 1'b1, 32'h0BADF00D});
        base = ack_cnt;
        @(posedge clk); #1;
        m0_addr = 32'h40; m0_req = 1;
        @(posedge clk); #1 m0_req = 0;
        repeat (8) @(negedge clk);
        check("drop_ack_count", ack_cnt, base + 1);
        check("drop_idle_rstrb", {31'h0, mem_rstrb}, 32'h0);

        // Back-to-back reads by m1
        sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        sb.push_back('{1'b1, 1'b1, 32'h3030C0DE});
        sb.push_back('{1'b1, 1'b1, 32'h0BADF00D});
        base = ack_cnt;
        @(posedge clk); #1;
        m1_addr = 32'h10; m1_wmask = 0; m1_req = 1;
        wait_acks(base + 1);
        m1_addr = 32'h30;
        wait_acks(base + 2);
        m1_addr = 32'h40;
        wait_acks(base + 3);
        m1_req = 0;
        if (ack_cnt == base + 3) begin
            check("b2b_gap1", ack_cyc[base + 1] - ack_cyc[base], 32'd3);
            check("b2b_gap2", ack_cyc[base + 2] - ack_cyc[base + 1], 32'd3);
        end else begin
            check("b2b_ack_count", ack_cnt, base + 3);
        end

        // Reset asserted in the middle of an m0 write
        base = ack_cnt;
        @(posedge clk); #1;
        m0_addr = 32'h50; m0_wdata = 32'hFFFFFFFF; m0_wmask = 4'b1111; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_wmask_before", {28'h0, mem_wmask}, 32'hF);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_wmask", {28'h0, mem_wmask}, 32'h0);
        check("rst_mid_rstrb", {31'h0, mem_rstrb}, 32'h0);
        check("rst_mid_ack", {30'h0, m1_ack, m0_ack}, 32'h0);
        m0_req = 0; m0_wmask = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mid_ram", ram[20], 32'h55555555);
        check("rst_mid_no_ack", ack_cnt, base);
        @(posedge clk); #1 reset = 1'b0;

        // First contention after reset must go to m0 with normal latency
        sb.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        m0_addr = 32'h10; m1_addr = 32'h30;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rstrb", {31'h0, mem_rstrb}, 32'h1);
        check("post_rst_addr", mem_addr, 32'h10);
        @(negedge clk);
        check("post_rst_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have, for each requester n in {0,1}, port mn_req, input, 1: level request, held until mn_ack.
REQ-005 SHALL have, per requester n, port mn_addr, input, XLEN: byte address of the request.
REQ-006 SHALL have, per requester n, port mn_wdata, input, XLEN: write data.
REQ-007 SHALL have, per requester n, port mn_wmask, input, 4: byte write mask; 0 means a read.
REQ-008 SHALL have, per requester n, port mn_rdata, output, XLEN: read data, valid while mn_ack=1.
REQ-009 SHALL have, per requester n, port mn_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port mem_addr, output, XLEN: address to RAM.
REQ-011 SHALL have port mem_wdata, output, XLEN: write data to RAM.
REQ-012 SHALL have port mem_wmask, output, 4: byte enables to RAM.
REQ-013 SHALL have port mem_rstrb, output, 1: read strobe to RAM.
REQ-014 SHALL have port mem_rdata, input, XLEN: RAM read data, valid the cycle after mem_rstrb.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; each of ACCESS and DONE lasts exactly one cycle.
REQ-016 SHALL sample mn_req only in IDLE; a request arriving in ACCESS or DONE waits until the next IDLE.
REQ-017 SHALL, in IDLE with any req high, pick a winner, latch its addr/wdata/wmask and the winner index, and enter ACCESS.
REQ-018 SHALL remain in IDLE, with all mem_* strobes 0, when no req is high.
REQ-019 SHALL, in ACCESS, drive latched mem_addr and mem_wdata, mem_wmask = latched wmask, and mem_rstrb = 1 iff latched wmask == 0.
REQ-020 SHALL drive mem_wmask = 0 and mem_rstrb = 0 in IDLE and DONE.
REQ-021 SHALL, in DONE, pulse ack of the latched winner only, with rdata = mem_rdata for reads; the non-winner's ack stays 0.
REQ-022 SHALL give a latency of 2 cycles from the IDLE sampling edge to ack: req sampled at edge N, ACCESS in cycle N..N+1, ack high in cycle N+1..N+2.
REQ-023 SHALL complete a latched transaction even if its req drops during ACCESS or DONE.
REQ-024 SHALL drive a non-acked mn_rdata as 0.
REQ-025 SHALL limit sustained throughput to one transaction per 3 cycles; the requester deasserts req, or presents its next request, on the edge at which ack is seen.
REQ-026 SHALL, on simultaneous requests, resolve the winner per REQ-034/REQ-035; the loser is served in the next IDLE if still requesting.

Reset
REQ-027 SHALL, while reset=1, force state IDLE and the last-winner register to 1 (so m0 wins first under round-robin).
REQ-028 SHALL, while reset=1, hold all outputs at 0: mn_ack, mn_rdata, mem_addr, mem_wdata, mem_wmask, mem_rstrb.
REQ-029 SHALL, on reset asserted mid-transaction, abandon the transaction with no ack and drop mem strobes asynchronously.
REQ-030 SHALL make its first sample, after reset deasserts, on the next rising edge in IDLE.

Configuration
REQ-031 SHALL compile the round-robin winner logic in or out with macro MEM_ARBITER_RR_EN.
REQ-032 SHALL, with MEM_ARBITER_RR_EN defined, update the last-winner register on each IDLE -> ACCESS transition.
REQ-033 SHALL, without MEM_ARBITER_RR_EN, have no last-winner register.
REQ-034 SHALL, with MEM_ARBITER_RR_EN defined, grant the requester other than the last winner when both request.
REQ-035 SHALL, without MEM_ARBITER_RR_EN, apply fixed priority with m0 always winning when both request.

Verification
REQ-036 SHALL cover single read: m0_req with addr=0x10, wmask=0, RAM[0x10]=0xDEADBEEF -> mem_rstrb=1 for one cycle, then m0_ack=1 with m0_rdata=0xDEADBEEF two cycles after sampling.
REQ-037 SHALL cover single write: m1_req with addr=0x20, wdata=0x12345678, wmask=4'b0011 -> mem_wmask=0011 for one cycle, m1_ack next cycle, RAM[0x20] low half = 0x5678.
REQ-038 SHALL cover contention: both req held for 4 transactions -> RR build grants m0,m1,m0,m1; fixed build grants m0 every time, m1 never acked.
REQ-039 SHALL cover early drop: m0_req dropped during ACCESS -> m0_ack still pulses once and no second transaction starts.
REQ-040 SHALL cover reset during ACCESS -> mem_rstrb/mem_wmask go 0 before the next edge, no ack, FSM in IDLE, and the first post-reset contention is won by m0.
REQ-041 SHALL cover back-to-back: m1 requests 3 reads continuously -> acks spaced exactly 3 cycles apart, and m0_ack stays 0.
